// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the APB read path: first-word-fall-through
// storage of {stop_err, parity_err, data} with fill level, watermark and sticky error flags.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESHOLD  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_parity_err,
  input  logic                  wr_stop_err,
  input  logic                  rd_en,
  input  logic                  clr_status,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_parity_err,
  output logic                  rd_stop_err,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  level_irq,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH       = 1 << DEPTH_LOG2;
  localparam int ENTRY_WIDTH = DATA_WIDTH + 2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] THRESH_C = (DEPTH_LOG2 + 1)'(THRESHOLD);

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [ENTRY_WIDTH-1:0] head;

  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  overflow_reg;
  logic                  overflow_next;
  logic                  underflow_reg;
  logic                  underflow_next;

  logic empty_int;
  logic full_int;
  logic do_push;
  logic do_pop;
  logic overflow_event;
  logic underflow_event;

  assign empty_int = (count_reg == '0);
  assign full_int  = (count_reg == DEPTH_C);

  // A pop frees the head slot in the same edge, so a write into a full FIFO
  // is accepted whenever a pop accompanies it.
  always_comb begin
    do_pop          = rd_en && !empty_int;
    do_push         = wr_en && (!full_int || do_pop);
    overflow_event  = wr_en && full_int && !rd_en;
    underflow_event = rd_en && empty_int;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) begin
      wr_ptr_next = wr_ptr_reg + DEPTH_LOG2'(1);
    end
    if (do_pop) begin
      rd_ptr_next = rd_ptr_reg + DEPTH_LOG2'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_next = count_reg - (DEPTH_LOG2 + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Set has priority over clear so an event in the clearing cycle is not lost.
  always_comb begin
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (clr_status) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (overflow_event) begin
      overflow_next = 1'b1;
    end
    if (underflow_event) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is not reset; a write coincident with reset is discarded.
  always_ff @(posedge CLK) begin
    if (!RST && do_push) begin
      mem[wr_ptr_reg] <= {wr_stop_err, wr_parity_err, wr_data};
    end
  end

  // Asynchronous read keeps the head visible right after the writing edge.
  assign head = mem[rd_ptr_reg];

  assign rd_data       = head[DATA_WIDTH-1:0];
  assign rd_parity_err = head[DATA_WIDTH];
  assign rd_stop_err   = head[DATA_WIDTH+1];

  assign count     = count_reg;
  assign empty     = empty_int;
  assign full      = full_int;
  assign level_irq = (count_reg >= THRESH_C);
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model predicts popped
// entries and status; a negedge monitor compares every pop the DUT performs.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_parity_err = 1'b0;
  logic          wr_stop_err = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_status = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_parity_err;
  logic          rd_stop_err;
  logic          empty;
  logic          full;
  logic [DL2:0]  count;
  logic          level_irq;
  logic          overflow;
  logic          underflow;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .THRESHOLD(THR)) dut (
    .CLK(CLK), .RST(RST),
    .wr_en(wr_en), .wr_data(wr_data), .wr_parity_err(wr_parity_err), .wr_stop_err(wr_stop_err),
    .rd_en(rd_en), .clr_status(clr_status),
    .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_stop_err(rd_stop_err),
    .empty(empty), .full(full), .count(count), .level_irq(level_irq),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  typedef logic [DW+1:0] entry_t;

  entry_t model_q[$];
  entry_t exp_q[$];
  bit     m_ovf = 1'b0;
  bit     m_udf = 1'b0;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic check_status(input string tag);
    int  exp_cnt;
    bit  e_empty, e_full, e_lvl;
    exp_cnt = model_q.size();
    e_empty = (exp_cnt == 0);
    e_full  = (exp_cnt == DEPTH);
    e_lvl   = (exp_cnt >= THR);
    vectors++;
    if (count !== (DL2+1)'(exp_cnt) || empty !== e_empty || full !== e_full ||
        level_irq !== e_lvl || overflow !== m_ovf || underflow !== m_udf) begin
      miscompares++;
      $display("FAIL status[%s] got cnt=%0d emp=%b ful=%b lvl=%b ovf=%b udf=%b exp cnt=%0d emp=%b ful=%b lvl=%b ovf=%b udf=%b",
               tag, count, empty, full, level_irq, overflow, underflow,
               exp_cnt, e_empty, e_full, e_lvl, m_ovf, m_udf);
    end
  endtask

  // One clock of stimulus; the model steps with the edge, then status is compared.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit p, input bit s,
                     input bit r, input bit clr, input bit rst, input string tag);
    bit ovf_set, udf_set;
    RST = rst; wr_en = w; wr_data = d; wr_parity_err = p; wr_stop_err = s;
    rd_en = r; clr_status = clr;
    if (r && !rst && model_q.size() > 0) exp_q.push_back(model_q[0]);
    @(posedge CLK);
    if (rst) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      ovf_set = 1'b0;
      udf_set = 1'b0;
      if (r) begin
        if (model_q.size() > 0) void'(model_q.pop_front());
        else udf_set = 1'b1;
      end
      if (w) begin
        if (model_q.size() < DEPTH) model_q.push_back({s, p, d});
        else ovf_set = 1'b1;
      end
      m_ovf = ovf_set | (m_ovf & ~clr);
      m_udf = udf_set | (m_udf & ~clr);
    end
    #1;
    check_status(tag);
  endtask

  task automatic push(input logic [DW-1:0] d, input bit p, input bit s);
    cyc(1'b1, d, p, s, 1'b0, 1'b0, 1'b0, "push");
  endtask

  task automatic pop();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "pop");
  endtask

  // Monitor: every pop the DUT accepts must match the oldest expected entry.
  always @(negedge CLK) begin
    entry_t e;
    if (!RST && rd_en && !empty) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected got data=%h par=%b stop=%b required no pop", rd_data, rd_parity_err, rd_stop_err);
      end else begin
        e = exp_q.pop_front();
        if ({rd_stop_err, rd_parity_err, rd_data} !== e) begin
          miscompares++;
          $display("FAIL pop_data got stop=%b par=%b data=%h required stop=%b par=%b data=%h",
                   rd_stop_err, rd_parity_err, rd_data, e[DW+1], e[DW], e[DW-1:0]);
        end else begin
          $display("pop data=%h par=%b stop=%b ok", rd_data, rd_parity_err, rd_stop_err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Ordered write/read
    push(8'hAA, 1'b0, 1'b0);
    push(8'h55, 1'b0, 1'b0);
    push(8'h0F, 1'b0, 1'b0);
    repeat (3) pop();

    // Error flag pass-through
    push(8'hAA, 1'b1, 1'b0);
    push(8'hAA, 1'b0, 1'b1);
    pop();
    pop();

    // Full, overflow, drain and pointer wrap
    for (int i = 0; i < DEPTH; i++) push(DW'(i), 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    repeat (DEPTH) pop();
    for (int i = 0; i < 20; i++) begin
      push(DW'(8'h80 + i), i[0], i[1]);
      pop();
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr");

    // Simultaneous push/pop at full and at empty
    for (int i = 0; i < DEPTH; i++) push(DW'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "wr_rd_full");
    repeat (DEPTH) pop();
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "wr_rd_empty");
    pop();
    pop();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr");

    // Reset mid-operation with a coincident write
    for (int i = 0; i < 5; i++) push(DW'(8'hC0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "rst_mid");
    push(8'h42, 1'b0, 1'b0);
    pop();

    // Randomised phases: write-heavy, balanced, read-heavy
    for (int ph = 0; ph < 4; ph++) begin
      int wp, rp;
      wp = (ph == 0) ? 80 : (ph == 3) ? 20 : 50;
      rp = (ph == 0) ? 20 : (ph == 3) ? 80 : 50;
      for (int k = 0; k < 200; k++) begin
        bit w, r, c, rs;
        w  = ($urandom_range(0, 99) < wp);
        r  = ($urandom_range(0, 99) < rp);
        c  = ($urandom_range(0, 15) == 0);
        rs = ($urandom_range(0, 299) == 0);
        cyc(w, DW'($urandom), 1'($urandom), 1'($urandom), r, c, rs, "random");
      end
    end

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending pops required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
